// File: rtl/stim_sequencer.sv
// Table-driven stimulus player: steps of {sw, btn, hold} driven for hold+1 cycles.
// Ports: CLK50MHZ/RST, WR_* table write, LEN/START/ABORT/LOOP control, SW/BTN/STEP_IDX/BUSY/DONE out.
module stim_sequencer #(
  parameter int SW_W   = 4,
  parameter int BTN_N  = 2,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = SW_W + BTN_N + HOLD_W
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [DW-1:0]    WR_DATA,
  input  logic [AW:0]      LEN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             LOOP,
  output logic [SW_W-1:0]  SW,
  output logic [BTN_N-1:0] BTN,
  output logic [AW-1:0]    STEP_IDX,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [AW:0] DLEN = (AW+1)'(DEPTH);

  state_t            state;
  logic [DW-1:0]     tbl [DEPTH];
  logic [HOLD_W-1:0] cnt;
  logic [AW:0]       len_r;
  logic [AW:0]       l_eff;
  logic              last;
  logic [AW-1:0]     nxt_idx;
  logic [DW-1:0]     nxt;

  assign l_eff   = (LEN > DLEN) ? DLEN : LEN;
  assign last    = ({1'b0, STEP_IDX} + (AW+1)'(1)) == len_r;
  // Entry is fetched only at load time so late table rewrites still apply.
  assign nxt_idx = (state == IDLE || last) ? '0 : STEP_IDX + AW'(1);
  assign nxt     = tbl[nxt_idx];

  always_ff @(posedge CLK50MHZ) begin
    if (WR_EN && ({1'b0, WR_ADDR} < DLEN))
      tbl[WR_ADDR] <= WR_DATA;
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      SW       <= '0;
      BTN      <= '0;
      STEP_IDX <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      cnt      <= '0;
      len_r    <= '0;
    end else begin
      DONE <= 1'b0;
      if (ABORT) begin
        state    <= IDLE;
        SW       <= '0;
        BTN      <= '0;
        STEP_IDX <= '0;
        BUSY     <= 1'b0;
        cnt      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (START && l_eff != '0) begin
              state    <= PLAY;
              len_r    <= l_eff;
              BUSY     <= 1'b1;
              SW       <= nxt[DW-1 -: SW_W];
              BTN      <= nxt[HOLD_W +: BTN_N];
              cnt      <= nxt[HOLD_W-1:0];
              STEP_IDX <= nxt_idx;
            end
          end
          PLAY: begin
            if (cnt != '0) begin
              cnt <= cnt - HOLD_W'(1);
            end else if (last && !LOOP) begin
              state    <= IDLE;
              SW       <= '0;
              BTN      <= '0;
              STEP_IDX <= '0;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
            end else begin
              SW       <= nxt[DW-1 -: SW_W];
              BTN      <= nxt[HOLD_W +: BTN_N];
              cnt      <= nxt[HOLD_W-1:0];
              STEP_IDX <= nxt_idx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer.
// Expected per-cycle trace is expanded from a table model: step i occupies H_i+1 cycles.
module tb_stim_sequencer;

  localparam int SW_W   = 4;
  localparam int BTN_N  = 2;
  localparam int DEPTH  = 16;
  localparam int HOLD_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int DW     = SW_W + BTN_N + HOLD_W;
  localparam int OW     = SW_W + BTN_N + AW + 2;
  localparam int QW     = SW_W + BTN_N + 2;

  logic             clk = 1'b0;
  logic             RST;
  logic             WR_EN;
  logic [AW-1:0]    WR_ADDR;
  logic [DW-1:0]    WR_DATA;
  logic [AW:0]      LEN;
  logic             START;
  logic             ABORT;
  logic             LOOP;
  logic [SW_W-1:0]  SW;
  logic [BTN_N-1:0] BTN;
  logic [AW-1:0]    STEP_IDX;
  logic             BUSY;
  logic             DONE;

  logic [DW-1:0] mdl [DEPTH];
  int vecs = 0;
  int errs = 0;

  stim_sequencer #(
    .SW_W(SW_W), .BTN_N(BTN_N), .DEPTH(DEPTH), .HOLD_W(HOLD_W)
  ) dut (
    .CLK50MHZ(clk), .RST(RST),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .LEN(LEN), .START(START), .ABORT(ABORT), .LOOP(LOOP),
    .SW(SW), .BTN(BTN), .STEP_IDX(STEP_IDX),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] snap();
    return {SW, BTN, STEP_IDX, BUSY, DONE};
  endfunction

  function automatic logic [QW-1:0] quiet();
    return {SW, BTN, BUSY, DONE};
  endfunction

  task automatic chk(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkq(string tag, logic [QW-1:0] obs, logic [QW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(int addr, logic [SW_W-1:0] s, logic [BTN_N-1:0] b,
                    logic [HOLD_W-1:0] h);
    WR_EN   = 1'b1;
    WR_ADDR = AW'(addr);
    WR_DATA = {s, b, h};
    @(negedge clk);
    WR_EN = 1'b0;
    if (addr < DEPTH) mdl[addr] = {s, b, h};
  endtask

  // Plays LEN=len; loops (passes-1) times, LOOP dropped at start of last pass.
  task automatic run(string tag, int len, bit hold_start, int passes);
    int L;
    int h;
    L = (len > DEPTH) ? DEPTH : len;
    LEN   = (AW+1)'(len);
    LOOP  = (passes > 1);
    START = 1'b1;
    @(negedge clk);
    START = hold_start;
    if (L == 0) begin
      START = 1'b0;
      repeat (3) begin
        chkq({tag, "_len0"}, quiet(), '0);
        @(negedge clk);
      end
      return;
    end
    for (int p = 0; p < passes; p++) begin
      LOOP = (p < passes - 1);
      for (int i = 0; i < L; i++) begin
        h = int'(mdl[i][HOLD_W-1:0]);
        for (int c = 0; c <= h; c++) begin
          chk(tag, snap(),
              {mdl[i][DW-1 -: SW_W], mdl[i][HOLD_W +: BTN_N], AW'(i), 2'b10});
          @(negedge clk);
        end
      end
    end
    START = 1'b0;
    chkq({tag, "_done"}, quiet(), QW'(1));
    @(negedge clk);
    chkq({tag, "_idle"}, quiet(), '0);
  endtask

  task automatic base_table();
    wr(0, 4'd4, 2'b00, 16'd49);
    wr(1, 4'd0, 2'b00, 16'd49);
    wr(2, 4'd0, 2'b10, 16'd24);
  endtask

  initial begin
    RST = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    LEN = '0; START = 1'b0; ABORT = 1'b0; LOOP = 1'b0;
    #1;
    chk("reset", snap(), '0);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    chk("post_reset", snap(), '0);

    base_table();
    run("basic", 3, 1'b0, 1);
    run("loop", 3, 1'b0, 3);

    // Abort 10 cycles into step 1, then ABORT held with START
    LEN = 3; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_pre", snap(), {4'd0, 2'b00, AW'(1), 2'b10});
    ABORT = 1'b1; START = 1'b1;
    @(negedge clk);
    chk("abort", snap(), '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_start", snap(), '0);
    end
    ABORT = 1'b0; START = 1'b0;
    @(negedge clk);
    chk("abort_rel", snap(), '0);

    run("len0", 0, 1'b0, 1);

    for (int i = 0; i < DEPTH; i++)
      wr(i, 4'($urandom), 2'($urandom), 16'($urandom_range(0, 3)));
    run("len_over", DEPTH + 5, 1'b0, 1);

    for (int i = 0; i < 4; i++)
      wr(i, 4'(i + 1), 2'(i), 16'd0);
    run("h0_busy_start", 4, 1'b1, 1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++)
        wr(i, 4'($urandom), 2'($urandom), 16'($urandom_range(0, 7)));
      run("rand", n, 1'($urandom), $urandom_range(1, 2));
    end

    // Asynchronous reset mid step 1
    base_table();
    LEN = 3; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (55) @(negedge clk);
    chk("rst_pre", snap(), {4'd0, 2'b00, AW'(1), 2'b10});
    #2 RST = 1'b0;
    #1 chk("rst_async", snap(), '0);
    @(negedge clk);
    RST = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", snap(), '0);
    end
    run("after_rst", 3, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
